// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS data-memory access stage:
//   - state_t         : access FSM encoding (ST_IDLE / ST_WAIT)
//   - TIMEOUT_CYCLES_DEFAULT : default request-cycle limit before an abort
//   - CNT_W           : width of the timeout counter for the default limit
//   - isMisaligned()  : word-alignment check on the two address LSBs
// The timeout feature itself is enabled by the MIPS_MEM_TIMEOUT_EN macro in
// the files that use this package.
// ----------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES_DEFAULT + 1);

  // A word access is misaligned when either of the two low address bits is set.
  function automatic logic isMisaligned(input logic [1:0] addrLsb);
    return (addrLsb != 2'b00);
  endfunction

endpackage : mips_mem_pkg

// File: rtl/mips_mem_timeout.sv
// ----------------------------------------------------------------------------
// mips_mem_timeout
// Request-cycle counter used by the memory stage to detect a hung memory.
// Built only when MIPS_MEM_TIMEOUT_EN is defined.
// Ports:
//   CLK, RST_N   clock / asynchronous active-low reset
//   CntLoad      load the counter with 1 (first request cycle was issued)
//   CntInc       count one more request cycle
//   CntClr       clear the counter (transaction finished or aborted)
//   CntTerminal  counter has reached TIMEOUT_CYCLES
// Clear has priority over load, load over increment.
// ----------------------------------------------------------------------------
module mips_mem_timeout
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CW             = CNT_W
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CntLoad,
  input  logic CntInc,
  input  logic CntClr,
  output logic CntTerminal
);

  logic [CW-1:0] cntQ;

  // Request-cycle counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cntQ <= {CW{1'b0}};
    end else if (CntClr) begin
      cntQ <= {CW{1'b0}};
    end else if (CntLoad) begin
      cntQ <= {{(CW-1){1'b0}}, 1'b1};
    end else if (CntInc) begin
      cntQ <= cntQ + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cntQ <= cntQ;
    end
  end

  assign CntTerminal = (cntQ == CW'(TIMEOUT_CYCLES));

endmodule : mips_mem_timeout

// File: rtl/mips_mem_stage.sv
// ----------------------------------------------------------------------------
// mips_mem_stage
// Data-memory access stage of the 5-stage MIPS pipeline (EX/MEM -> MEM/WB).
// Converts load/store control into a DMemReq/DMemReady handshake, stalls the
// upstream pipeline while memory is busy and sends bubbles (RegWriteOut = 0)
// into MEM/WB during the stall. Misaligned word accesses are dropped and
// flagged in the sticky MisalignErr.
//
// Optional feature: define MIPS_MEM_TIMEOUT_EN to abort a request that has
// been outstanding for TIMEOUT_CYCLES cycles and set the sticky BusErr.
// Without it the stage waits indefinitely and BusErr is tied to 0.
//
// Ports:
//   CLK, RST_N                    clock / asynchronous active-low reset
//   MemReadMEM, MemWriteMEM       load / store control from EX/MEM
//   MemtoregMEM, RegWriteMEM      WB control from EX/MEM
//   ALUResultMEM, WriteDataMEM    effective address / store data
//   WriteRegMEM                   destination register
//   MemtoregOut, RegWriteOut      WB control to MEM/WB (RegWriteOut gated)
//   ALUResultOut, WriteRegOut     pass-through to MEM/WB
//   MemReadDataMEM                load data to MEM/WB (0 unless completing)
//   StallMEM                      freezes PC, IF/ID, ID/EX, EX/MEM
//   DMemReq/We/Addr/WData         data-memory request side
//   DMemRData, DMemReady          data-memory response side
//   MisalignErr, BusErr           sticky error flags
// ----------------------------------------------------------------------------
module mips_mem_stage
  import mips_mem_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          MemReadMEM,
  input  logic          MemWriteMEM,
  input  logic          MemtoregMEM,
  input  logic          RegWriteMEM,
  input  logic [AW-1:0] ALUResultMEM,
  input  logic [DW-1:0] WriteDataMEM,
  input  logic [4:0]    WriteRegMEM,
  output logic          MemtoregOut,
  output logic          RegWriteOut,
  output logic [AW-1:0] ALUResultOut,
  output logic [4:0]    WriteRegOut,
  output logic [DW-1:0] MemReadDataMEM,
  output logic          StallMEM,
  output logic          DMemReq,
  output logic          DMemWe,
  output logic [AW-1:0] DMemAddr,
  output logic [DW-1:0] DMemWData,
  input  logic [DW-1:0] DMemRData,
  input  logic          DMemReady,
  output logic          MisalignErr,
  output logic          BusErr
);

  state_t stateQ;
  state_t stateD;
  logic   op;
  logic   mis;
  logic   reqRaw;
  logic   abort;
  logic   done;
  logic   misErrQ;
  logic   busErrQ;

`ifdef MIPS_MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic cntLoad;
  logic cntInc;
  logic cntClr;
  logic cntTerminal;

  mips_mem_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (CntW)
  ) uTimeout (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CntLoad     (cntLoad),
    .CntInc      (cntInc),
    .CntClr      (cntClr),
    .CntTerminal (cntTerminal)
  );
`endif

  assign op  = MemReadMEM | MemWriteMEM;
  assign mis = op & isMisaligned(ALUResultMEM[1:0]);

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state and request decode (request is Mealy in IDLE).
  always_comb begin
    stateD = stateQ;
    reqRaw = 1'b0;
    abort  = 1'b0;
`ifdef MIPS_MEM_TIMEOUT_EN
    cntLoad = 1'b0;
    cntInc  = 1'b0;
    cntClr  = 1'b0;
`endif
    case (stateQ)
      ST_IDLE: begin
        if (op && !mis) begin
          reqRaw = 1'b1;
          if (!DMemReady) begin
            stateD = ST_WAIT;
`ifdef MIPS_MEM_TIMEOUT_EN
            cntLoad = 1'b1;
`endif
          end else begin
            stateD = ST_IDLE;
          end
        end else begin
          stateD = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (DMemReady) begin
          // Completion cycle: the next instruction starts from IDLE.
          reqRaw = 1'b1;
          stateD = ST_IDLE;
`ifdef MIPS_MEM_TIMEOUT_EN
          cntClr = 1'b1;
        end else if (cntTerminal) begin
          // Request has been held TIMEOUT_CYCLES cycles: drop it.
          abort  = 1'b1;
          stateD = ST_IDLE;
          cntClr = 1'b1;
`endif
        end else begin
          reqRaw = 1'b1;
          stateD = ST_WAIT;
`ifdef MIPS_MEM_TIMEOUT_EN
          cntInc = 1'b1;
`endif
        end
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // Gating with RST_N makes the request drop as soon as reset asserts,
  // even in the middle of a transaction.
  assign DMemReq   = reqRaw & RST_N;
  assign StallMEM  = DMemReq & ~DMemReady;
  assign done      = DMemReq & DMemReady;
  assign DMemWe    = DMemReq & MemWriteMEM;
  assign DMemAddr  = ALUResultMEM;
  assign DMemWData = WriteDataMEM;

  // A stalled, misaligned or aborted cycle writes a bubble into MEM/WB.
  assign RegWriteOut    = RegWriteMEM & ~StallMEM & ~mis & ~abort;
  assign MemtoregOut    = MemtoregMEM;
  assign ALUResultOut   = ALUResultMEM;
  assign WriteRegOut    = WriteRegMEM;
  assign MemReadDataMEM = done ? DMemRData : {DW{1'b0}};

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      misErrQ <= 1'b0;
      busErrQ <= 1'b0;
    end else begin
      misErrQ <= misErrQ | mis;
      busErrQ <= busErrQ | abort;
    end
  end

  assign MisalignErr = misErrQ;
`ifdef MIPS_MEM_TIMEOUT_EN
  assign BusErr = busErrQ;
`else
  assign BusErr = 1'b0;
`endif

endmodule : mips_mem_stage

// File: doc/mips_mem_stage.md
# mips_mem_stage

Data-memory access stage of the 5-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register and turns the load/store control from EX/MEM into a request/ready transaction on the data-memory port. It stalls the pipeline while memory is busy, inserts bubbles toward MEM/WB during a stall, and flags misaligned accesses and hung memory.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYCLES, 255, maximum request cycles before abort (only with the timeout macro)

Ports:
- CLK  in  1  pipeline clock; every flop updates on the rising edge
- RST_N  in  1  asynchronous active-low reset
- MemReadMEM, MemWriteMEM  in  1 each  load/store control from EX/MEM
- MemtoregMEM, RegWriteMEM  in  1 each  WB control from EX/MEM
- ALUResultMEM  in  AW  effective address, also the ALU result
- WriteDataMEM  in  DW  store data
- WriteRegMEM  in  5  destination register
- MemtoregOut, RegWriteOut  out  1 each  to MEM/WB; RegWriteOut is gated
- ALUResultOut  out  AW  to MEM/WB
- WriteRegOut  out  5  to MEM/WB
- MemReadDataMEM  out  DW  load data to MEM/WB
- StallMEM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- DMemReq  out  1  memory request
- DMemWe  out  1  1 = write
- DMemAddr  out  AW  word address, equal to ALUResultMEM
- DMemWData  out  DW  store data
- DMemRData  in  DW  read data, valid when DMemReady = 1
- DMemReady  in  1  transaction completes this cycle
- MisalignErr  out  1  sticky
- BusErr  out  1  sticky; tied 0 without the timeout macro

## Operation
- Definitions:
  - op = MemReadMEM | MemWriteMEM.
  - mis = op & (ALUResultMEM[1:0] != 0).
- FSM states: IDLE and WAIT. A timeout counter cnt holds the number of request cycles issued so far.
- IDLE:
  - If op & !mis, assert DMemReq combinationally (Mealy).
  - If DMemReady is also high that cycle, the access completes with zero stall and the state stays IDLE.
  - Otherwise the next state is WAIT and cnt is loaded with 1.
- IDLE with mis:
  - No request is issued.
  - RegWriteOut is forced to 0.
  - MisalignErr is set at the next edge.
  - No stall occurs.
- WAIT:
  - DMemReq is held high; the address and data are stable because EX/MEM is frozen.
  - If DMemReady is high: the access completes and the next state is IDLE.
  - Otherwise cnt increments.
- StallMEM = DMemReq & !DMemReady.
- RegWriteOut = RegWriteMEM & !StallMEM & !mis & !abort. A stalled cycle therefore writes a bubble into MEM/WB.
- MemtoregOut, ALUResultOut and WriteRegOut pass through unchanged.
- MemReadDataMEM = DMemRData in the completion cycle and 0 otherwise.
- A store drives DMemWe = 1 and DMemWData = WriteDataMEM. If MemReadMEM and MemWriteMEM are both set, the access is treated as a store.
- Back-to-back accesses: the completion cycle returns the FSM to IDLE, so the next instruction's request starts in the following cycle. There is no duplicate access.
- Reset, including mid-transaction:
  - state = IDLE, cnt = 0, MisalignErr = 0, BusErr = 0.
  - DMemReq falls immediately because it is gated by the async reset.

## Timing
- Zero-wait memory: no stall cycles; load data reaches MEM/WB at the same edge as ALUResultOut.
- N-wait memory (DMemReady arrives N cycles after the first request cycle): StallMEM is high for exactly N cycles, and N bubbles enter MEM/WB.
- Sticky errors are visible on the cycle after the triggering event.
- Output values in reset:
  - StallMEM = 0, DMemReq = 0.
  - RegWriteOut = 0, because no op is in flight (reset EX/MEM content is 0).
  - MemReadDataMEM = 0.

## Configuration
- MIPS_MEM_TIMEOUT_EN defined:
  - In WAIT, when cnt == TIMEOUT_CYCLES and DMemReady = 0, that cycle is an abort cycle.
  - In the abort cycle: DMemReq = 0, StallMEM = 0, RegWriteOut = 0, and BusErr is set.
  - The FSM then returns to IDLE.
  - DMemReq is therefore high for exactly TIMEOUT_CYCLES cycles before the abort.
- MIPS_MEM_TIMEOUT_EN undefined:
  - The stage waits indefinitely.
  - The counter is not built, BusErr = 0 and abort = 0.

## Structure
- The shared package/include mips_mem_pkg holds:
  - the state encodings (ST_IDLE = 1'b0, ST_WAIT = 1'b1);
  - the default TIMEOUT_CYCLES;
  - the counter width, clog2(TIMEOUT_CYCLES+1).
- One sub-module, mips_mem_timeout: a counter with load/increment/clear and a terminal flag. It is instantiated only under MIPS_MEM_TIMEOUT_EN.

## Test plan
- Zero-wait load: LW to address 0x10, DMemReady held at 1, DMemRData = 0xDEADBEEF → StallMEM stays 0; MEM/WB captures 0xDEADBEEF and RegWrite = 1 on the same edge.
- 3-wait store: SW with address 0x20 and data 0x1234 → DMemReq high for 4 cycles, StallMEM high for 3, DMemWe = 1, three bubbles with RegWriteOut = 0.
- Misaligned LW to address 0x13 → DMemReq stays 0, RegWriteOut = 0, no stall, MisalignErr = 1 from the next cycle until reset.
- Timeout with TIMEOUT_CYCLES = 4 and DMemReady never high → DMemReq high for 4 cycles, 5th cycle has StallMEM = 0 and RegWriteOut = 0, BusErr = 1 afterwards. Without the macro, the stall persists.
- Two back-to-back LWs, each with 1 wait cycle → two distinct request windows separated by the completion cycle; correct data for each in MEM/WB.
- RST_N asserted while in WAIT → DMemReq and StallMEM fall asynchronously; after release the FSM is IDLE and both error flags are 0.
